// File: rtl/rv32i_cpu_core.sv
// Single-cycle RV32I core with optional MUL (low 32 bits of product).
// Harvard interface: combinational instruction/data reads, data writes commit on the clock edge.
`timescale 1ns/1ps
module rv32i_cpu_core #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          ENABLE_MUL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] d_mem_addr,
    output logic [31:0] d_mem_wdata,
    output logic [3:0]  d_mem_wen,
    input  logic [31:0] d_mem_rdata
);

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OPIMM  = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_e;

    logic [31:0] pc_q, pc_d, pc_nxt, pc_plus4;
    logic [31:0] rf_q [32];

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2, shamt;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, op_b, ls_addr;
    logic [31:0] alu_res, mul_res, sra_res, wb_data, wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [3:0]  wen;
    logic        is_op, alu_ok, wb_en, taken;

    assign opcode = i_mem_rdata[6:0];
    assign rd     = i_mem_rdata[11:7];
    assign funct3 = i_mem_rdata[14:12];
    assign rs1    = i_mem_rdata[19:15];
    assign rs2    = i_mem_rdata[24:20];
    assign funct7 = i_mem_rdata[31:25];

    assign imm_i = {{20{i_mem_rdata[31]}}, i_mem_rdata[31:20]};
    assign imm_s = {{20{i_mem_rdata[31]}}, i_mem_rdata[31:25], i_mem_rdata[11:7]};
    assign imm_b = {{19{i_mem_rdata[31]}}, i_mem_rdata[31], i_mem_rdata[7],
                    i_mem_rdata[30:25], i_mem_rdata[11:8], 1'b0};
    assign imm_u = {i_mem_rdata[31:12], 12'b0};
    assign imm_j = {{11{i_mem_rdata[31]}}, i_mem_rdata[31], i_mem_rdata[19:12],
                    i_mem_rdata[20], i_mem_rdata[30:21], 1'b0};

    assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];

    assign is_op   = (opcode == OPC_OP);
    assign op_b    = is_op ? rs2_val : imm_i;
    assign shamt   = op_b[4:0];
    assign mul_res = rs1_val * op_b;
    assign sra_res = $signed(rs1_val) >>> shamt;
    assign ls_addr = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);

    // Memory returns the aligned word; pick lanes from the low address bits.
    assign ld_byte = 8'(d_mem_rdata >> {ls_addr[1:0], 3'b000});
    assign ld_half = ls_addr[1] ? d_mem_rdata[31:16] : d_mem_rdata[15:0];

    always_comb begin
        alu_res = '0;
        alu_ok  = 1'b1;
        case (funct3)
            3'b000: begin
                if (!is_op || funct7 == 7'b0000000)         alu_res = rs1_val + op_b;
                else if (funct7 == 7'b0100000)              alu_res = rs1_val - op_b;
                else if (ENABLE_MUL && funct7 == 7'b0000001) alu_res = mul_res;
                else                                        alu_ok  = 1'b0;
            end
            3'b001: begin
                alu_res = rs1_val << shamt;
                alu_ok  = (funct7 == 7'b0000000);
            end
            3'b010: begin
                alu_res = {31'b0, $signed(rs1_val) < $signed(op_b)};
                alu_ok  = !is_op || funct7 == 7'b0000000;
            end
            3'b011: begin
                alu_res = {31'b0, rs1_val < op_b};
                alu_ok  = !is_op || funct7 == 7'b0000000;
            end
            3'b100: begin
                alu_res = rs1_val ^ op_b;
                alu_ok  = !is_op || funct7 == 7'b0000000;
            end
            3'b101: begin
                alu_res = funct7[5] ? sra_res : rs1_val >> shamt;
                alu_ok  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            end
            3'b110: begin
                alu_res = rs1_val | op_b;
                alu_ok  = !is_op || funct7 == 7'b0000000;
            end
            default: begin
                alu_res = rs1_val & op_b;
                alu_ok  = !is_op || funct7 == 7'b0000000;
            end
        endcase
    end

    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        pc_nxt   = pc_plus4;
        wb_en    = 1'b0;
        wb_data  = alu_res;
        wdata    = rs2_val;
        wen      = '0;
        taken    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                wb_en   = 1'b1;
                wb_data = imm_u;
            end
            OPC_AUIPC: begin
                wb_en   = 1'b1;
                wb_data = pc_q + imm_u;
            end
            OPC_JAL: begin
                wb_en   = 1'b1;
                wb_data = pc_plus4;
                pc_nxt  = pc_q + imm_j;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    wb_en   = 1'b1;
                    wb_data = pc_plus4;
                    pc_nxt  = ls_addr & ~32'd1;
                end
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  taken = (rs1_val == rs2_val);
                    3'b001:  taken = (rs1_val != rs2_val);
                    3'b100:  taken = ($signed(rs1_val) < $signed(rs2_val));
                    3'b101:  taken = !($signed(rs1_val) < $signed(rs2_val));
                    3'b110:  taken = (rs1_val < rs2_val);
                    3'b111:  taken = !(rs1_val < rs2_val);
                    default: taken = 1'b0;
                endcase
                if (taken) pc_nxt = pc_q + imm_b;
            end
            OPC_LOAD: begin
                wb_en = 1'b1;
                case (funct3)
                    3'b000:  wb_data = {{24{ld_byte[7]}}, ld_byte};
                    3'b001:  wb_data = {{16{ld_half[15]}}, ld_half};
                    3'b010:  wb_data = d_mem_rdata;
                    3'b100:  wb_data = {24'b0, ld_byte};
                    3'b101:  wb_data = {16'b0, ld_half};
                    default: wb_en   = 1'b0;
                endcase
            end
            OPC_STORE: begin
                case (funct3)
                    3'b000: begin
                        wdata = {4{rs2_val[7:0]}};
                        wen   = 4'b0001 << ls_addr[1:0];
                    end
                    3'b001: begin
                        wdata = {2{rs2_val[15:0]}};
                        wen   = ls_addr[1] ? 4'b1100 : 4'b0011;
                    end
                    3'b010:  wen = 4'b1111;
                    default: wen = '0;
                endcase
            end
            OPC_OPIMM, OPC_OP: wb_en = alu_ok;
            default: ;
        endcase
        pc_d = {pc_nxt[31:2], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            pc_q <= pc_d;
            if (wb_en && rd != 5'd0) rf_q[rd] <= wb_data;
        end
    end

    assign i_mem_addr  = pc_q;
    assign d_mem_addr  = (opcode == OPC_OP || opcode == OPC_OPIMM) ? alu_res : ls_addr;
    assign d_mem_wdata = wdata;
    assign d_mem_wen   = rst_n ? wen : '0;

endmodule

// File: tb/tb_rv32i_cpu_core.sv
// Bench for rv32i_cpu_core: directed programs, expected stores queued at load time and
// checked by an independent store monitor; reset and fetch sequencing checked directly.
`timescale 1ns/1ps
module tb_rv32i_cpu_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_mem_addr, i_mem_rdata, d_mem_addr, d_mem_wdata, d_mem_rdata;
    logic [3:0]  d_mem_wen;

    rv32i_cpu_core #(.RESET_PC(32'h0000_0000), .ENABLE_MUL(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mem_addr  (i_mem_addr),
        .i_mem_rdata (i_mem_rdata),
        .d_mem_addr  (d_mem_addr),
        .d_mem_wdata (d_mem_wdata),
        .d_mem_wen   (d_mem_wen),
        .d_mem_rdata (d_mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [256];
    logic [31:0] dmem [1024];

    assign i_mem_rdata = imem[i_mem_addr[9:2]];
    assign d_mem_rdata = dmem[d_mem_addr[11:2]];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (d_mem_wen[b]) dmem[d_mem_addr[11:2]][b*8 +: 8] <= d_mem_wdata[b*8 +: 8];
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wen;
    } store_t;

    store_t      exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_store  = 0;
    int unsigned pc_w     = 0;
    logic [11:0] st_addr  = '0;

    // Store monitor: every DUT store must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n && d_mem_wen != 4'b0000) begin
            store_t e;
            n_checks++;
            n_store++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL store#%0d: unexpected store addr=%h data=%h wen=%b, required no store",
                         n_store, d_mem_addr, d_mem_wdata, d_mem_wen);
            end else begin
                e = exp_q.pop_front();
                if (d_mem_addr !== e.addr || d_mem_wdata !== e.data || d_mem_wen !== e.wen) begin
                    n_fail++;
                    $display("FAIL store#%0d: got addr=%h data=%h wen=%b, required addr=%h data=%h wen=%b",
                             n_store, d_mem_addr, d_mem_wdata, d_mem_wen, e.addr, e.data, e.wen);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] alui(input logic [2:0] f3, input logic [4:0] rd, rs1,
                                         input logic [11:0] imm);
        return enc_i(imm, rs1, f3, rd, 7'b0010011);
    endfunction
    function automatic logic [31:0] ld(input logic [2:0] f3, input logic [4:0] rd, rs1,
                                       input logic [11:0] imm);
        return enc_i(imm, rs1, f3, rd, 7'b0000011);
    endfunction

    task automatic emit(input logic [31:0] w);
        imem[pc_w] = w;
        pc_w++;
    endtask

    task automatic expect_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        store_t e;
        e.addr = a;
        e.data = d;
        e.wen  = m;
        exp_q.push_back(e);
    endtask

    // SW rs -> next result slot, and queue the word the store must carry.
    task automatic chk(input logic [4:0] rs, input logic [31:0] val);
        emit(enc_s(st_addr, rs, 5'd0, 3'b010));
        expect_st({20'b0, st_addr}, val, 4'hF);
        st_addr = st_addr + 12'd4;
    endtask

    task automatic start_prog(input logic [11:0] slot_base);
        @(posedge clk);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 256; i++) imem[i] = '0;
        for (int i = 0; i < 1024; i++) dmem[i] = '0;
        pc_w    = 0;
        st_addr = slot_base;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_drain(input string name, input int budget);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d stores pending after %0d cycles, required 0", name, exp_q.size(), cyc);
            exp_q.delete();
        end
    endtask

    int fib [10] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};

    initial begin
        // Program 1: reset, fetch order, ALU/MUL results, x0 hardwired.
        start_prog(12'h100);
        emit(enc_s(12'h0FC, 5'd0, 5'd0, 3'b010));
        expect_st(32'h0FC, 32'h0, 4'hF);
        emit(alui(3'b000, 5'd0, 5'd0, 12'd7));         chk(5'd0, 32'h0);
        emit(alui(3'b000, 5'd1, 5'd0, 12'd5));
        emit(alui(3'b000, 5'd2, 5'd0, 12'(-3)));
        emit(enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3)); chk(5'd3, 32'h0000_0002);
        emit(enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd4)); chk(5'd4, 32'hFFFF_FFF1);
        emit(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd5)); chk(5'd5, 32'h0000_0008);
        emit(enc_r(7'b0000000, 5'd1, 5'd2, 3'b010, 5'd5)); chk(5'd5, 32'h0000_0001);
        emit(enc_r(7'b0000000, 5'd1, 5'd2, 3'b011, 5'd5)); chk(5'd5, 32'h0000_0000);
        emit(enc_r(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd5)); chk(5'd5, 32'hFFFF_FFF8);
        emit(enc_r(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd5)); chk(5'd5, 32'hFFFF_FFFD);
        emit(enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd5)); chk(5'd5, 32'h0000_0005);
        emit(enc_r(7'b0000000, 5'd1, 5'd2, 3'b001, 5'd5)); chk(5'd5, 32'hFFFF_FFA0);
        emit(enc_r(7'b0000000, 5'd1, 5'd2, 3'b101, 5'd5)); chk(5'd5, 32'h07FF_FFFF);
        emit(enc_r(7'b0100000, 5'd1, 5'd2, 3'b101, 5'd5)); chk(5'd5, 32'hFFFF_FFFF);
        emit(alui(3'b000, 5'd6, 5'd0, 12'd33));
        emit(enc_r(7'b0000000, 5'd6, 5'd1, 3'b001, 5'd5)); chk(5'd5, 32'h0000_000A);
        emit(alui(3'b010, 5'd5, 5'd2, 12'(-2)));       chk(5'd5, 32'h0000_0001);
        emit(alui(3'b011, 5'd5, 5'd1, 12'hFFF));       chk(5'd5, 32'h0000_0001);
        emit(alui(3'b100, 5'd5, 5'd1, 12'h7FF));       chk(5'd5, 32'h0000_07FA);
        emit(alui(3'b110, 5'd5, 5'd1, 12'h00A));       chk(5'd5, 32'h0000_000F);
        emit(alui(3'b111, 5'd5, 5'd2, 12'h0FF));       chk(5'd5, 32'h0000_00FD);
        emit(alui(3'b001, 5'd5, 5'd1, 12'd31));        chk(5'd5, 32'h8000_0000);
        emit(alui(3'b101, 5'd5, 5'd2, 12'd28));        chk(5'd5, 32'h0000_000F);
        emit(alui(3'b101, 5'd5, 5'd2, 12'h401));       chk(5'd5, 32'hFFFF_FFFE);
        emit(enc_u(20'h12345, 5'd5, 7'b0110111));      chk(5'd5, 32'h1234_5000);
        begin
            logic [31:0] auipc_pc;
            auipc_pc = pc_w * 4;
            emit(enc_u(20'h00001, 5'd5, 7'b0010111));  chk(5'd5, auipc_pc + 32'h1000);
        end
        emit(enc_u(20'h80000, 5'd6, 7'b0110111));
        emit(enc_r(7'b0000000, 5'd6, 5'd6, 3'b000, 5'd5)); chk(5'd5, 32'h0000_0000);
        emit(alui(3'b000, 5'd5, 5'd6, 12'hFFF));       chk(5'd5, 32'h7FFF_FFFF);
        emit(enc_j(21'd0, 5'd0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_pc", i_mem_addr, 32'h0);
        check("reset_wen", {28'b0, d_mem_wen}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("reset_wen_held", {28'b0, d_mem_wen}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("fetch%0d", k), i_mem_addr, 32'(k * 4));
        end
        run_drain("alu_prog", 200);

        // Program 2: Fibonacci through memory with a BNE back-edge.
        start_prog(12'h000);
        emit(alui(3'b000, 5'd10, 5'd0, 12'h200));
        emit(alui(3'b000, 5'd11, 5'd0, 12'h228));
        emit(alui(3'b000, 5'd1, 5'd0, 12'd1));
        emit(enc_s(12'd0, 5'd1, 5'd10, 3'b010));
        emit(enc_s(12'd4, 5'd1, 5'd10, 3'b010));
        emit(alui(3'b000, 5'd10, 5'd10, 12'd8));
        emit(ld(3'b010, 5'd2, 5'd10, 12'hFF8));
        emit(ld(3'b010, 5'd3, 5'd10, 12'hFFC));
        emit(enc_r(7'b0000000, 5'd3, 5'd2, 3'b000, 5'd4));
        emit(enc_s(12'd0, 5'd4, 5'd10, 3'b010));
        emit(alui(3'b000, 5'd10, 5'd10, 12'd4));
        emit(enc_b(13'(-20), 5'd11, 5'd10, 3'b001));
        emit(enc_j(21'd0, 5'd0));
        for (int i = 0; i < 10; i++) expect_st(32'h200 + 32'(i * 4), 32'(fib[i]), 4'hF);
        release_reset();
        run_drain("fibonacci", 500);

        // Program 3: sub-word stores/loads, misaligned access, branch conditions.
        start_prog(12'h380);
        emit(alui(3'b000, 5'd1, 5'd0, 12'h0AB));
        emit(enc_s(12'h303, 5'd1, 5'd0, 3'b000)); expect_st(32'h303, 32'hABAB_ABAB, 4'b1000);
        emit(enc_s(12'h301, 5'd1, 5'd0, 3'b000)); expect_st(32'h301, 32'hABAB_ABAB, 4'b0010);
        emit(ld(3'b000, 5'd2, 5'd0, 12'h303));    chk(5'd2, 32'hFFFF_FFAB);
        emit(ld(3'b100, 5'd3, 5'd0, 12'h303));    chk(5'd3, 32'h0000_00AB);
        emit(ld(3'b010, 5'd6, 5'd0, 12'h302));    chk(5'd6, 32'hAB00_AB00);
        emit(alui(3'b000, 5'd4, 5'd0, 12'h857));
        emit(enc_s(12'h306, 5'd4, 5'd0, 3'b001)); expect_st(32'h306, 32'hF857_F857, 4'b1100);
        emit(enc_s(12'h309, 5'd4, 5'd0, 3'b001)); expect_st(32'h309, 32'hF857_F857, 4'b0011);
        emit(ld(3'b001, 5'd5, 5'd0, 12'h306));    chk(5'd5, 32'hFFFF_F857);
        emit(ld(3'b101, 5'd5, 5'd0, 12'h306));    chk(5'd5, 32'h0000_F857);
        emit(ld(3'b001, 5'd5, 5'd0, 12'h309));    chk(5'd5, 32'hFFFF_F857);
        emit(alui(3'b000, 5'd7, 5'd0, 12'hFFF));
        emit(alui(3'b000, 5'd8, 5'd0, 12'd1));
        emit(enc_b(13'd8, 5'd8, 5'd7, 3'b100));
        emit(enc_s(12'h3F0, 5'd0, 5'd0, 3'b010));
        emit(alui(3'b000, 5'd9, 5'd0, 12'd1));    chk(5'd9, 32'd1);
        emit(enc_b(13'd8, 5'd8, 5'd7, 3'b110));
        emit(alui(3'b000, 5'd9, 5'd0, 12'd2));    chk(5'd9, 32'd2);
        emit(enc_b(13'd8, 5'd8, 5'd7, 3'b101));
        emit(alui(3'b000, 5'd9, 5'd0, 12'd3));    chk(5'd9, 32'd3);
        emit(enc_b(13'd8, 5'd8, 5'd7, 3'b111));
        emit(alui(3'b000, 5'd9, 5'd0, 12'd4));    chk(5'd9, 32'd3);
        emit(enc_b(13'd8, 5'd8, 5'd8, 3'b000));
        emit(alui(3'b000, 5'd9, 5'd0, 12'd5));    chk(5'd9, 32'd3);
        emit(enc_b(13'd8, 5'd8, 5'd7, 3'b001));
        emit(alui(3'b000, 5'd9, 5'd0, 12'd6));    chk(5'd9, 32'd3);
        emit(enc_j(21'd0, 5'd0));
        release_reset();
        run_drain("subword_branch", 200);

        // Program 4: JAL at 0x10, JALR with odd target, then reset mid-program.
        start_prog(12'h400);
        emit(alui(3'b000, 5'd0, 5'd0, 12'd7));
        chk(5'd0, 32'h0);
        emit(alui(3'b000, 5'd12, 5'd0, 12'h025));
        emit(alui(3'b000, 5'd9, 5'd0, 12'd0));
        emit(enc_j(21'd8, 5'd1));
        emit(enc_s(12'h4F0, 5'd0, 5'd0, 3'b010));
        chk(5'd1, 32'h0000_0014);
        emit(enc_i(12'd2, 5'd12, 3'b000, 5'd13, 7'b1100111));
        emit(enc_s(12'h4F0, 5'd0, 5'd0, 3'b010));
        chk(5'd13, 32'h0000_0020);
        emit(enc_j(21'd0, 5'd0));
        release_reset();
        run_drain("jumps", 200);
        check("loop_pc", i_mem_addr, 32'h28);

        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_pc", i_mem_addr, 32'h0);
        check("midreset_wen", {28'b0, d_mem_wen}, 32'h0);
        start_prog(12'h500);
        chk(5'd1, 32'h0);
        chk(5'd12, 32'h0);
        chk(5'd13, 32'h0);
        emit(enc_j(21'd0, 5'd0));
        release_reset();
        run_drain("regs_cleared", 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
